// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers: fixed-latency mult/div with a busy
// window, direct HI/LO writes, and a combinational HI/LO read port.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        En,
   input  logic [2:0]  MDop,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [1:0]  ismd,
   output logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDout
);

   localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [2:0] OP_NONE  = 3'b000;
   localparam logic [2:0] OP_MTHI  = 3'b001;
   localparam logic [2:0] OP_MTLO  = 3'b010;
   localparam logic [2:0] OP_MULT  = 3'b011;
   localparam logic [2:0] OP_MULTU = 3'b100;
   localparam logic [2:0] OP_DIV   = 3'b101;
   localparam logic [2:0] OP_DIVU  = 3'b110;

   logic [0:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       op_reg, op_next;
   logic [31:0]      a_reg, a_next;
   logic [31:0]      b_reg, b_next;
   logic [31:0]      hi_reg, hi_next;
   logic [31:0]      lo_reg, lo_next;

   logic [2:0]  op_eff;
   logic        is_md_op;
   logic        is_signed;
   logic [63:0] a_ext, b_ext, prod;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, quo_mag, rem_mag, quo, rem;

   assign op_eff   = En ? MDop : OP_NONE;
   assign is_md_op = (op_eff == OP_MULT) || (op_eff == OP_MULTU) ||
                     (op_eff == OP_DIV)  || (op_eff == OP_DIVU);
   assign Start    = is_md_op && (state_reg == ST_IDLE);

   // Results are always computed from the latched operands, never from A/B.
   assign is_signed = (op_reg == OP_MULT) || (op_reg == OP_DIV);
   assign a_ext     = {{32{is_signed & a_reg[31]}}, a_reg};
   assign b_ext     = {{32{is_signed & b_reg[31]}}, b_reg};
   assign prod      = a_ext * b_ext;

   // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
   assign a_neg   = is_signed & a_reg[31];
   assign b_neg   = is_signed & b_reg[31];
   assign a_mag   = a_neg ? (32'd0 - a_reg) : a_reg;
   assign b_mag   = b_neg ? (32'd0 - b_reg) : b_reg;
   assign quo_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
   assign rem_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
   assign quo     = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
   assign rem     = a_neg ? (32'd0 - rem_mag) : rem_mag;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      op_next    = op_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
      case (state_reg)
         ST_IDLE: begin
            if (Start) begin
               op_next    = op_eff;
               a_next     = A;
               b_next     = B;
               cnt_next   = ((op_eff == OP_MULT) || (op_eff == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;
               state_next = ST_BUSY;
            end else if (op_eff == OP_MTHI) begin
               hi_next = A;
            end else if (op_eff == OP_MTLO) begin
               lo_next = A;
            end
         end
         default: begin
            cnt_next = cnt_reg - CNT_ONE;
            if (cnt_reg == CNT_ONE) begin
               state_next = ST_IDLE;
               case (op_reg)
                  OP_MULT, OP_MULTU: begin
                     hi_next = prod[63:32];
                     lo_next = prod[31:0];
                  end
                  OP_DIV, OP_DIVU: begin
                     if (b_reg != 32'd0) begin
                        hi_next = rem;
                        lo_next = quo;
                     end
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         op_reg    <= OP_NONE;
         a_reg     <= 32'd0;
         b_reg     <= 32'd0;
         hi_reg    <= 32'd0;
         lo_reg    <= 32'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         op_reg    <= op_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         hi_reg    <= hi_next;
         lo_reg    <= lo_next;
      end
   end

   assign Busy = (state_reg == ST_BUSY);
   assign HI   = hi_reg;
   assign LO   = lo_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_mdout
         assign MDout[gi] = ((ismd == 2'b01) & hi_reg[gi]) | ((ismd == 2'b10) & lo_reg[gi]);
      end
   endgenerate

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, multi-cycle corner
// sequences, and randomized ops against an arithmetic reference model.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        En;
   logic [2:0]  MDop;
   logic [31:0] A, B;
   logic [1:0]  ismd;
   logic        Start, Busy;
   logic [31:0] HI, LO, MDout;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .En(En), .MDop(MDop), .A(A), .B(B), .ismd(ismd),
      .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .MDout(MDout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_hi, model_lo;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
      string       name;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int op_cycles(input logic [2:0] op);
      return (op == 3'b011 || op == 3'b100) ? 5 : 10;
   endfunction

   // Reference: arithmetic straight from the instruction definitions.
   task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      case (op)
         3'b001: model_hi = a;
         3'b010: model_lo = a;
         3'b011: begin
            p = 64'(longint'($signed(a)) * longint'($signed(b)));
            {model_hi, model_lo} = p;
         end
         3'b100: begin
            p = {32'd0, a} * {32'd0, b};
            {model_hi, model_lo} = p;
         end
         3'b101: if (b != 0) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               model_lo = 32'h80000000;
               model_hi = 32'h0;
            end else begin
               model_lo = 32'($signed(a) / $signed(b));
               model_hi = 32'($signed(a) % $signed(b));
            end
         end
         3'b110: if (b != 0) begin
            model_lo = a / b;
            model_hi = a % b;
         end
         default: ;
      endcase
   endtask

   task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
      En = 1'b1; MDop = 3'b001; A = h;
      tick();
      MDop = 3'b010; A = l;
      tick();
      MDop = 3'b000;
      model_hi = h;
      model_lo = l;
   endtask

   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int cycles;
      logic [31:0] old_hi;
      logic hold_bad;
      old_hi = HI;
      En = 1'b1; MDop = op; A = a; B = b; ismd = 2'b01;
      #1;
      check({name, " start"}, 32'(Start), 32'd1);
      tick();
      MDop = 3'b000; A = $urandom; B = $urandom;
      cycles = 0;
      hold_bad = 1'b0;
      while (Busy && cycles < 50) begin
         cycles++;
         if (MDout !== old_hi || HI !== old_hi) hold_bad = 1'b1;
         tick();
      end
      check({name, " busy_cycles"}, 32'(cycles), 32'(op_cycles(op)));
      check({name, " hi_hold"}, 32'(hold_bad), 32'd0);
      check({name, " HI"}, HI, exp_hi);
      check({name, " LO"}, LO, exp_lo);
      model_hi = exp_hi;
      model_lo = exp_lo;
      $display("txn %-14s op=%03b A=%08h B=%08h -> HI=%08h LO=%08h busy=%0d",
               name, op, a, b, HI, LO, cycles);
   endtask

   initial begin
      vecs[0] = '{3'b011, 32'hFFFFFFFE, 32'd3,        32'h1234, 32'h5678, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg"};
      vecs[1] = '{3'b100, 32'hFFFFFFFF, 32'd2,        32'h1234, 32'h5678, 32'h00000001, 32'hFFFFFFFE, "multu"};
      vecs[2] = '{3'b101, 32'hFFFFFFF9, 32'd2,        32'h1234, 32'h5678, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg"};
      vecs[3] = '{3'b110, 32'd5,        32'd0,        32'h11,   32'h22,   32'h11,       32'h22,       "divu_zero"};
      vecs[4] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h1234, 32'h5678, 32'h0,        32'h80000000, "div_ovf"};
      vecs[5] = '{3'b110, 32'd100,      32'd7,        32'h1234, 32'h5678, 32'd2,        32'd14,       "divu"};
      vecs[6] = '{3'b101, 32'd7,        32'hFFFFFFFE, 32'h1234, 32'h5678, 32'd1,        32'hFFFFFFFD, "div_negdiv"};
      vecs[7] = '{3'b101, 32'hFFFFFFF0, 32'd0,        32'h33,   32'h44,   32'h33,       32'h44,       "div_zero"};
      vecs[8] = '{3'b011, 32'h80000000, 32'h80000000, 32'h1234, 32'h5678, 32'h40000000, 32'h0,        "mult_min"};
      vecs[9] = '{3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234, 32'h5678, 32'hFFFFFFFE, 32'h00000001, "multu_max"};

      reset = 1'b1; En = 1'b0; MDop = 3'b000; A = '0; B = '0; ismd = 2'b00;
      model_hi = '0; model_lo = '0;
      tick(); tick();
      check("reset HI", HI, 32'h0);
      check("reset LO", LO, 32'h0);
      check("reset Busy", 32'(Busy), 32'd0);
      check("reset MDout", MDout, 32'h0);

      // Start is combinational during reset but must not launch anything.
      En = 1'b1; MDop = 3'b011; A = 32'd3; B = 32'd4;
      #1;
      check("start_in_reset", 32'(Start), 32'd1);
      tick();
      check("busy_after_reset_start", 32'(Busy), 32'd0);
      MDop = 3'b000;
      reset = 1'b0;
      tick();
      $display("txn reset done");

      for (int i = 0; i < 10; i++) begin
         write_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);
      end

      // En=0 and reserved op must not start.
      En = 1'b0; MDop = 3'b101; B = 32'd1;
      #1;
      check("en0 start", 32'(Start), 32'd0);
      En = 1'b1; MDop = 3'b111;
      #1;
      check("reserved start", 32'(Start), 32'd0);
      tick();
      check("reserved busy", 32'(Busy), 32'd0);
      MDop = 3'b000;
      ismd = 2'b10;
      #1;
      check("MDout LO", MDout, LO);
      ismd = 2'b11;
      #1;
      check("MDout 11", MDout, 32'h0);
      $display("txn en0/reserved/readout");

      // mthi issued during a mult is ignored; MDout keeps reading the old HI.
      begin
         int cyc;
         write_hilo(32'hAAAA, 32'hBBBB);
         En = 1'b1; MDop = 3'b011; A = 32'd7; B = 32'd9; ismd = 2'b01;
         tick();
         MDop = 3'b000;
         tick();
         MDop = 3'b001; A = 32'h5;
         #1;
         check("ign start", 32'(Start), 32'd0);
         tick();
         MDop = 3'b000;
         check("ign MDout", MDout, 32'hAAAA);
         cyc = 0;
         while (Busy && cyc < 50) begin cyc++; tick(); end
         check("ign done", 32'(cyc), 32'd3);
         check("ign HI", HI, 32'h0);
         check("ign LO", LO, 32'd63);
         $display("txn ignored_mthi HI=%08h LO=%08h", HI, LO);
      end

      // Reset in busy cycle 3 of a div discards the op.
      write_hilo(32'h1, 32'h2);
      En = 1'b1; MDop = 3'b101; A = 32'd100; B = 32'd3;
      tick();
      MDop = 3'b000;
      tick(); tick();
      check("rst_mid busy", 32'(Busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_mid Busy", 32'(Busy), 32'd0);
      check("rst_mid HI", HI, 32'h0);
      check("rst_mid LO", LO, 32'h0);
      $display("txn reset_mid_div HI=%08h LO=%08h", HI, LO);
      run_op("mult_after_rst", 3'b011, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);

      // Randomized ops against the model.
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         int r;
         op = 3'($urandom_range(0, 7));
         a = (($urandom_range(0, 7)) == 0) ? 32'h80000000 : $urandom;
         r = $urandom_range(0, 9);
         b = (r == 0) ? 32'd0 : (r == 1) ? 32'($urandom_range(1, 16)) :
             (r == 2) ? 32'hFFFFFFFF : $urandom;
         if (op >= 3'b011 && op <= 3'b110) begin
            model_apply(op, a, b);
            run_op("rand", op, a, b, model_hi, model_lo);
         end else begin
            En = 1'b1; MDop = op; A = a; B = b;
            #1;
            check("rand nostart", 32'(Start), 32'd0);
            tick();
            MDop = 3'b000;
            model_apply(op, a, b);
            check("rand busy", 32'(Busy), 32'd0);
            check("rand HI", HI, model_hi);
            check("rand LO", LO, model_lo);
            $display("txn rand op=%03b A=%08h -> HI=%08h LO=%08h", op, a, HI, LO);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: Busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: Busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 En  input  1  E-stage instruction valid; En=0 makes MDop behave as 3'b000.
REQ-006 MDop  input  3  op code: 000 none, 001 mthi, 010 mtlo, 011 mult, 100 multu, 101 div, 110 divu, 111 reserved, treated as none.
REQ-007 A  input  32  rs operand.
REQ-008 B  input  32  rt operand.
REQ-009 ismd  input  2  read select: 01 HI, 10 LO, else 0.
REQ-010 Start  output  1  combinational; the mult/div op is accepted this cycle.
REQ-011 Busy  output  1  registered; a mult/div op is in progress.
REQ-012 HI  output  32  registered HI.
REQ-013 LO  output  32  registered LO.
REQ-014 MDout  output  32  combinational; HI if ismd=01, LO if ismd=10, else 32'h0.

Function
REQ-015 States SHALL be IDLE and BUSY, plus a down-counter wide enough for DIV_CYCLES.
REQ-016 Start SHALL be 1 iff En=1, Busy=0, and MDop is in {011,100,101,110}.
REQ-017 On an edge with Start=1: latch A, B, and the op; load the counter with N (MULT_CYCLES or DIV_CYCLES); enter BUSY.
REQ-018 Latency: a Start in cycle T gives Busy=1 in cycles T+1..T+N.
REQ-019 At the edge ending cycle T+N: write HI/LO, Busy->0, return to IDLE; new values are visible from cycle T+N+1.
REQ-020 mult: {HI,LO} = signed(A)*signed(B), full 64-bit product.
REQ-021 multu: {HI,LO} = unsigned 64-bit product.
REQ-022 div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-023 div overflow case, A=32'h80000000 and B=32'hFFFFFFFF: LO=32'h80000000, HI=0.
REQ-024 divu: LO = A/B and HI = A%B, both unsigned.
REQ-025 div/divu with B=0: still takes the full DIV_CYCLES of Busy; HI and LO are left unchanged.
REQ-026 mthi/mtlo with En=1 and Busy=0: HI (or LO) <= A at the next edge; no Busy, Start=0.
REQ-027 Any MDop presented while Busy=1 SHALL have no effect on state; results come only from the latched operands. The stall logic upstream prevents this case.
REQ-028 HI/LO SHALL change only at the REQ-019 edge, on a REQ-026 write, or on reset.
REQ-029 MDout SHALL return pre-operation HI/LO while Busy=1.
REQ-030 Busy=0 and Start=1 in the same cycle a previous op completes is impossible, because Busy is still 1 in cycle T+N.
REQ-031 A new op is accepted no earlier than cycle T+N+1, back-to-back with no bubble.

Reset
REQ-032 reset=1 at an edge SHALL force HI=0, LO=0, Busy=0, counter=0, state IDLE, and clear the latched operands and op.
REQ-033 reset SHALL have priority over Start and over completion; an in-flight result is discarded and HI/LO are not written.
REQ-034 Start SHALL still evaluate combinationally during reset; its acceptance has no effect while reset=1.

Verification
REQ-035 Signed mult: A=32'hFFFFFFFE (-2), B=3, MDop=011, En=1 -> Start=1; Busy=1 for exactly 5 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
REQ-036 Unsigned mult: A=32'hFFFFFFFF, B=2, MDop=100 -> after 5 Busy cycles HI=1, LO=32'hFFFFFFFE.
REQ-037 Signed div: A=-7 (32'hFFFFFFF9), B=2, MDop=101 -> 10 Busy cycles; LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
REQ-038 Divide by zero: HI=32'h11, LO=32'h22, divu with B=0 -> 10 Busy cycles; HI/LO stay 32'h11/32'h22.
REQ-039 Ignored op and readout: mult in flight, MDop=001 with A=32'h5 on cycle 2 of Busy -> HI not written to 5, final HI is the product; ismd=01 reads the old HI during Busy.
REQ-040 Reset mid-operation: reset asserted in Busy cycle 3 of a div -> next cycle Busy=0, HI=LO=0; a mult issued immediately afterwards completes normally in 5 cycles.
